pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use clock clk, rising-edge; reset rst, synchronous, active-high.
REQ-002 Ports SHALL be as listed (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs_D, rt_D  in  5  source register numbers of the D-stage instruction
- Tuse_rs_D, Tuse_rt_D  in  2  cycles until each operand is needed; 3 = operand unused
- A3_E, A3_M  in  5  destination register in E / M
- WE_E, WE_M  in  1  register-write enable in E / M
- Tnew_E, Tnew_M  in  2  cycles until the E / M result is available
- md_use_D  in  1  D instruction uses the mult/div unit (mult, div, mfhi, mflo, mthi, mtlo)
- md_start_E  in  1  one-cycle pulse: mult/div instruction entering E this cycle
- md_op_E  in  1  0 = mult, 1 = div
- en_PC, en_FD  out  1  PC / F-D register enable
- flush_DE  out  1  D-E register clear (bubble insert)
- en_EM, en_MW  out  1  E-M / M-W register enables
- md_busy  out  1  mult/div unit occupied
- stall  out  1  combined stall
- stall_cnt  out  32  stall-cycle counter (only when STALL_CNT_EN is defined)

Function
REQ-003 stall_rs SHALL be 1 when rs_D!=0 and either (WE_E, A3_E==rs_D, Tuse_rs_D<Tnew_E) or (WE_M, A3_M==rs_D, Tuse_rs_D<Tnew_M).
REQ-004 stall_rt SHALL follow REQ-003 with rt_D and Tuse_rt_D.
REQ-005 stall_md SHALL be 1 when md_use_D and (md_busy or md_start_E).
REQ-006 stall SHALL equal stall_rs | stall_rt | stall_md, computed combinationally in the same cycle.
REQ-007 en_PC and en_FD SHALL equal ~stall; flush_DE SHALL equal stall; en_EM and en_MW SHALL be constant 1.
REQ-008 The mult/div sequencer SHALL have two states: IDLE and BUSY, with a 4-bit down-counter md_cnt.
REQ-009 In IDLE, md_start_E SHALL load md_cnt with 5 for mult or 10 for div and move to BUSY at the next edge.
REQ-010 In BUSY, md_cnt SHALL decrement by 1 per cycle; the state SHALL return to IDLE on the edge where md_cnt goes 1->0.
REQ-011 md_busy SHALL be 1 exactly while the state is BUSY: 5 cycles for mult, 10 for div, beginning the cycle after the start pulse.
REQ-012 md_start_E asserted while BUSY SHALL be ignored; the counter SHALL continue unchanged.
REQ-013 The ignored start SHALL NOT be able to occur in legal flow because of REQ-005.
REQ-014 An instruction in D with md_use_D=1 SHALL advance on the first cycle after md_busy falls.
REQ-015 A hazard in which Tnew equals Tuse SHALL NOT stall; forwarding covers it.

Reset
REQ-016 On rst at a rising edge, the state SHALL become IDLE, md_cnt SHALL become 0, md_busy SHALL become 0, and stall_cnt SHALL become 0.
REQ-017 rst asserted mid-BUSY SHALL abort the operation; md_busy SHALL be 0 on the following cycle.
REQ-018 While rst is high, md_start_E SHALL be ignored.
REQ-019 Combinational outputs SHALL follow their inputs during reset, with md_busy held at 0.

Configuration
REQ-020 When STALL_CNT_EN is defined, stall_cnt SHALL increment by 1 on every edge where stall=1 and rst=0.
- The counter SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 When STALL_CNT_EN is not defined, the stall_cnt port and its register SHALL be absent.
- All other behaviour SHALL be unchanged.

Verification
REQ-022 Load-use case: A3_E=5, WE_E=1, Tnew_E=2, rs_D=5, Tuse_rs_D=1 -> stall=1, en_PC=0, en_FD=0, flush_DE=1.
REQ-023 Forwardable case: A3_M=7, WE_M=1, Tnew_M=1, rt_D=7, Tuse_rt_D=1 -> stall=0.
- Same stimulus with rt_D=0 and Tnew_M=2 -> stall=0.
REQ-024 div then mflo: md_start_E=1, md_op_E=1, md_use_D=1 on cycle 0 -> stall=1 for cycles 0..10, md_busy=1 for cycles 1..10, stall=0 on cycle 11.
REQ-025 mult then independent add: md_start_E=1, md_op_E=0, md_use_D=0 -> stall=0 throughout, md_busy=1 for exactly 5 cycles.
REQ-026 Reset mid-div: rst=1 on cycle 4 of BUSY -> md_busy=0 on cycle 5.
- With STALL_CNT_EN defined: stall_cnt=0.
- Subsequent mflo SHALL NOT stall.
REQ-027 With STALL_CNT_EN defined: stall_cnt preset via 0xFFFFFFFF stall cycles (or forced) plus one more stall -> stall_cnt=0.
- Without the macro, the bench SHALL compile without the port.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : pipeline hazard controller - RAW stall detection against E/M writers plus mult/div busy sequencer.
// Latency : stall/enables/flush are combinational in the same cycle; md_busy is registered (rises the cycle after a start).
// Backpr. : stall freezes PC and F-D, inserts a bubble into D-E; E-M and M-W always advance.
// Ports   : clk, rst (sync, active-high); D-stage rs/rt + Tuse; E/M A3, WE, Tnew; md_use_D, md_start_E, md_op_E;
//           outputs en_PC, en_FD, flush_DE, en_EM, en_MW, md_busy, stall, and stall_cnt when STALL_CNT_EN is defined.
// Config  : `define STALL_CNT_EN adds a free-running 32-bit stall-cycle counter (wraps to 0).
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_E,
  input  logic [4:0] A3_M,
  input  logic       WE_E,
  input  logic       WE_M,
  input  logic [1:0] Tnew_E,
  input  logic [1:0] Tnew_M,
  input  logic       md_use_D,
  input  logic       md_start_E,
  input  logic       md_op_E,
  output logic       en_PC,
  output logic       en_FD,
  output logic       flush_DE,
  output logic       en_EM,
  output logic       en_MW,
  output logic       md_busy,
  output logic       stall
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t  md_state;
  logic [3:0] md_cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  // A producer only forces a stall if its result arrives strictly later than
  // the consumer needs it; Tnew == Tuse is resolved by forwarding. Tuse = 3
  // never satisfies Tuse < Tnew, so unused operands drop out naturally.
  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               ((WE_E && (A3_E == rs_D) && (Tuse_rs_D < Tnew_E)) ||
                (WE_M && (A3_M == rs_D) && (Tuse_rs_D < Tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               ((WE_E && (A3_E == rt_D) && (Tuse_rt_D < Tnew_E)) ||
                (WE_M && (A3_M == rt_D) && (Tuse_rt_D < Tnew_M)));
    // md_start_E is included so a mult/div consumer directly behind the
    // starting instruction is held before md_busy has had a chance to rise.
    stall_md = md_use_D && (md_busy || md_start_E);
  end

  assign stall    = stall_rs | stall_rt | stall_md;
  assign en_PC    = ~stall;
  assign en_FD    = ~stall;
  assign flush_DE = stall;
  assign en_EM    = 1'b1;
  assign en_MW    = 1'b1;

  // Mult/div sequencer. md_busy is kept as its own register, updated in
  // lockstep with md_state, so it is a clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= IDLE;
      md_cnt   <= 4'd0;
      md_busy  <= 1'b0;
    end else begin
      case (md_state)
        IDLE: begin
          if (md_start_E) begin
            md_cnt   <= md_op_E ? 4'd10 : 4'd5;
            md_state <= BUSY;
            md_busy  <= 1'b1;
          end
        end
        BUSY: begin
          // A start seen here is ignored; the running operation owns the unit.
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1) begin
            md_state <= IDLE;
            md_busy  <= 1'b0;
          end
        end
        default: begin
          md_state <= IDLE;
          md_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_D, rt_D, A3_E, A3_M;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic       WE_E, WE_M, md_use_D, md_start_E, md_op_E;
  logic       en_PC, en_FD, flush_DE, en_EM, en_MW, md_busy, stall;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .A3_E(A3_E), .A3_M(A3_M), .WE_E(WE_E), .WE_M(WE_M),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .md_use_D(md_use_D), .md_start_E(md_start_E), .md_op_E(md_op_E),
    .en_PC(en_PC), .en_FD(en_FD), .flush_DE(flush_DE), .en_EM(en_EM), .en_MW(en_MW),
    .md_busy(md_busy), .stall(stall)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: the unit is busy during the cycle window (start, busy_end].
  longint     cyc = 0;
  longint     busy_end = -1;
  logic [31:0] m_cnt = 32'd0;

  function automatic bit m_busy();
    return cyc <= busy_end;
  endfunction

  function automatic bit m_hz(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0) return 1'b0;
    if (WE_E && A3_E == r && int'(tuse) < int'(Tnew_E)) return 1'b1;
    if (WE_M && A3_M == r && int'(tuse) < int'(Tnew_M)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return m_hz(rs_D, Tuse_rs_D) || m_hz(rt_D, Tuse_rt_D) ||
           (md_use_D && (m_busy() || md_start_E));
  endfunction

  always @(posedge clk) begin
    bit s;
    s = m_stall();
    if (rst) begin
      busy_end = cyc;
      m_cnt = 32'd0;
    end else begin
      if (s) m_cnt = m_cnt + 32'd1;
      if (md_start_E && !m_busy()) busy_end = cyc + (md_op_E ? 10 : 5);
    end
    cyc = cyc + 1;
  end

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    A3_E = 0; A3_M = 0; WE_E = 0; WE_M = 0; Tnew_E = 0; Tnew_M = 0;
    md_use_D = 0; md_start_E = 0; md_op_E = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1; md_start_E = 1; md_op_E = 1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    tests_run++;
    if (en_EM !== 1'b1 || en_MW !== 1'b1) begin tests_failed++; $display("FAIL reset_en_EM_MW: got %b%b want 11", en_EM, en_MW); end
    // Combinational path still live during reset.
    md_start_E = 0; A3_E = 5'd9; WE_E = 1; Tnew_E = 2'd2; rs_D = 5'd9; Tuse_rs_D = 2'd0;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_comb_stall: got %b want 1", stall); end
    @(negedge clk);
    clear_inputs(); rst = 0;
    #1;
    tests_run++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL post_reset: busy %b stall %b want 0 0", md_busy, stall); end
`ifdef STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    A3_E = 5'd5; WE_E = 1; Tnew_E = 2'd2; rs_D = 5'd5; Tuse_rs_D = 2'd1;
    #1;
    tests_run++;
    if ({stall, en_PC, en_FD, flush_DE} !== 4'b1001) begin
      tests_failed++; $display("FAIL load_use: got stall/enPC/enFD/flush %b%b%b%b want 1001", stall, en_PC, en_FD, flush_DE);
    end
    Tnew_E = 2'd1;  // Tnew == Tuse: forwarded, no stall
    #1;
    tests_run++;
    if (stall !== 1'b0 || en_PC !== 1'b1) begin tests_failed++; $display("FAIL tnew_eq_tuse: stall %b enPC %b want 0 1", stall, en_PC); end
    Tnew_E = 2'd2; WE_E = 0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL no_write_enable: got %b want 0", stall); end
    WE_E = 1; Tuse_rs_D = 2'd3;  // operand unused
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL tuse_unused: got %b want 0", stall); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    A3_M = 5'd7; WE_M = 1; Tnew_M = 2'd1; rt_D = 5'd7; Tuse_rt_D = 2'd1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL forward_m: got %b want 0", stall); end
    Tnew_M = 2'd2;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin tests_failed++; $display("FAIL rt_stall_m: got %b want 1", stall); end
    rt_D = 5'd0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL r0_no_stall: got %b want 0", stall); end
  endtask

  task automatic test_div_mflo();
    @(negedge clk);
    clear_inputs();
    for (int k = 0; k <= 11; k++) begin
      md_start_E = (k == 0); md_op_E = 1; md_use_D = 1;
      #1;
      tests_run++;
      if (stall !== (k <= 10) || md_busy !== (k >= 1 && k <= 10)) begin
        tests_failed++; $display("FAIL div_mflo c%0d: stall %b busy %b want %b %b", k, stall, md_busy, (k <= 10), (k >= 1 && k <= 10));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mult_indep();
    clear_inputs();
    for (int k = 0; k <= 7; k++) begin
      md_start_E = (k == 0); md_op_E = 0; md_use_D = 0;
      #1;
      tests_run++;
      if (stall !== 1'b0 || md_busy !== (k >= 1 && k <= 5)) begin
        tests_failed++; $display("FAIL mult_indep c%0d: stall %b busy %b want 0 %b", k, stall, md_busy, (k >= 1 && k <= 5));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_div();
    clear_inputs();
    for (int k = 0; k <= 5; k++) begin
      md_start_E = (k == 0); md_op_E = 1;
      rst = (k == 4);
      md_start_E = md_start_E | (k == 4);  // start during reset is ignored
      #1;
      if (k == 3) begin
        tests_run++;
        if (md_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_div_busy: got %b want 1", md_busy); end
      end
      if (k == 5) begin
        tests_run++;
        if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_abort: got %b want 0", md_busy); end
`ifdef STALL_CNT_EN
        tests_run++;
        if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL abort_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        md_use_D = 1;  // mflo
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL mflo_after_abort: got %b want 0", stall); end
      end
      @(negedge clk);
    end
    clear_inputs(); rst = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 40) == 0);
      rs_D       = 5'($urandom_range(0, 3));
      rt_D       = 5'($urandom_range(0, 3));
      A3_E       = 5'($urandom_range(0, 3));
      A3_M       = 5'($urandom_range(0, 3));
      Tuse_rs_D  = 2'($urandom_range(0, 3));
      Tuse_rt_D  = 2'($urandom_range(0, 3));
      Tnew_E     = 2'($urandom_range(0, 3));
      Tnew_M     = 2'($urandom_range(0, 3));
      WE_E       = 1'($urandom_range(0, 1));
      WE_M       = 1'($urandom_range(0, 1));
      md_use_D   = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 7) == 0);
      md_op_E    = 1'($urandom_range(0, 1));
      #1;
      tests_run++;
      if (stall !== m_stall() || en_PC !== !m_stall() || en_FD !== !m_stall() ||
          flush_DE !== m_stall() || md_busy !== m_busy()) begin
        tests_failed++;
        $display("FAIL random c%0d: stall %b enPC %b enFD %b flush %b busy %b want stall %b busy %b",
                 k, stall, en_PC, en_FD, flush_DE, md_busy, m_stall(), m_busy());
      end
`ifdef STALL_CNT_EN
      tests_run++;
      if (stall_cnt !== m_cnt) begin tests_failed++; $display("FAIL random_cnt c%0d: got %0d want %0d", k, stall_cnt, m_cnt); end
`endif
    end
    @(negedge clk);
    clear_inputs(); rst = 0;
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt_wrap();
    @(negedge clk);
    clear_inputs();
    A3_E = 5'd5; WE_E = 1; Tnew_E = 2'd2; rs_D = 5'd5; Tuse_rs_D = 2'd1;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    tests_run++;
    if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL stall_cnt_wrap: got %h want 00000000", stall_cnt); end
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forward();
    test_div_mflo();
    test_mult_indep();
    test_reset_mid_div();
    test_random();
`ifdef STALL_CNT_EN
    test_stall_cnt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
